step_phase_decoder: RTL

STEP_PHASE_DECODER -- requirements
Module: step_phase_decoder

---
 rtl/step_pkg.sv | 43 ++++
 rtl/phase_sync.sv | 32 +++
 rtl/step_phase_decoder.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/step_pkg.sv
// Shared definitions for the stepper phase decoder.
//   - one-hot phase code constants driven by the stepMotor driver
//   - FSM state enumeration
//   - ph_decode(): maps a 4-bit phase code to {valid, idx}
package step_pkg;

  localparam logic [3:0] PH_OFF  = 4'b0000;
  localparam logic [3:0] PH_IDX0 = 4'b0001;
  localparam logic [3:0] PH_IDX1 = 4'b0010;
  localparam logic [3:0] PH_IDX2 = 4'b0100;
  localparam logic [3:0] PH_IDX3 = 4'b1000;

  // Stall timer width; covers the largest supported STALL_CYCLES (2^24-1).
  localparam int STALL_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // no phase reference held
    ST_TRACK = 2'd1,  // reference held, decoding steps
    ST_FAULT = 2'd2   // sticky fault, waiting for err_clr
  } state_e;

  typedef struct packed {
    logic       valid;  // code is one of the four legal one-hot patterns
    logic [1:0] idx;    // phase index 0..3 when valid
  } ph_dec_t;

  // OFF (0000) and every multi-hot pattern decode as not valid; the caller
  // separates OFF from ILLEGAL.
  function automatic ph_dec_t ph_decode(input logic [3:0] code);
    ph_dec_t d;
    d.valid = 1'b1;
    d.idx   = 2'd0;
    case (code)
      PH_IDX0: d.idx = 2'd0;
      PH_IDX1: d.idx = 2'd1;
      PH_IDX2: d.idx = 2'd2;
      PH_IDX3: d.idx = 2'd3;
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/phase_sync.sv
// Two-flop synchronizer for the 4-bit motor phase pattern.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset, clears both stages to 0000
//   d_i  - phase pattern, asynchronous to clk
//   q_o  - synchronized phase pattern (second stage)
module phase_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  // NOTE: registers are written with non-blocking assignments so every flop
  // samples the pre-edge value of its source; blocking here would collapse
  // the two stages into one.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 4'b0000;
      sync_q <= 4'b0000;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/step_phase_decoder.sv
// Decodes the one-hot phase sequence of a stepper driver into a signed
// position, direction, per-step strobe, sticky fault and stall indication.
// Ports:
//   clk        - system clock, all state updates on its rising edge
//   rst        - synchronous active-high reset, overrides every other input
//   ph         - motor phase pattern, asynchronous to clk
//   pos_clr    - synchronous clear of pos (wins over a coincident step)
//   err_clr    - clears the sticky fault (only acts in FAULT)
//   pos        - signed step position, wraps modulo 2^POS_W
//   dir        - direction of last valid step (1 forward, 0 reverse)
//   step_pulse - one-cycle strobe per decoded step
//   err        - sticky fault flag
//   stalled    - in TRACK with no step for STALL_CYCLES cycles
module step_phase_decoder
  import step_pkg::*;
#(
  parameter int POS_W        = 16,
  parameter int STALL_CYCLES = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              ph,
  input  logic                    pos_clr,
  input  logic                    err_clr,
  output logic signed [POS_W-1:0] pos,
  output logic                    dir,
  output logic                    step_pulse,
  output logic                    err,
  output logic                    stalled
);

  localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_CYCLES);

  logic [3:0] phs;    // synchronized phase code
  logic [3:0] php_q;  // phs delayed by one cycle

  state_e             state_q, state_d;
  logic [1:0]         ref_q, ref_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               dir_q, dir_d;
  logic               step_q, step_d;
  logic               err_q, err_d;
  logic               stalled_q, stalled_d;
  logic [STALL_W-1:0] cnt_q, cnt_d;

  ph_dec_t dec;
  logic    is_off;
  logic    changed;

  phase_sync u_phase_sync (
    .clk (clk),
    .rst (rst),
    .d_i (ph),
    .q_o (phs)
  );

  assign dec     = ph_decode(phs);
  assign is_off  = (phs == PH_OFF);
  // A held code always matches the reference (it was loaded or stepped to
  // on the cycle it arrived), so TRACK only has work to do on a change.
  assign changed = (phs != php_q);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    ref_d   = ref_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (dec.valid) begin
          state_d = ST_TRACK;
          ref_d   = dec.idx;
          cnt_d   = '0;
        end else if (!is_off) begin
          state_d = ST_FAULT;
        end
      end

      ST_TRACK: begin
        if (changed && is_off) begin
          state_d = ST_IDLE;
        end else if (changed && !dec.valid) begin
          state_d = ST_FAULT;
        end else if (changed && dec.idx == 2'(ref_q + 2'd1)) begin
          pos_d  = pos_q + POS_W'(1);
          dir_d  = 1'b1;
          step_d = 1'b1;
          ref_d  = dec.idx;
          cnt_d  = '0;
        end else if (changed && dec.idx == 2'(ref_q - 2'd1)) begin
          pos_d  = pos_q - POS_W'(1);
          dir_d  = 1'b0;
          step_d = 1'b1;
          ref_d  = dec.idx;
          cnt_d  = '0;
        end else if (changed && dec.idx != ref_q) begin
          // Opposite phase: a step was skipped, direction is unknowable.
          state_d = ST_FAULT;
        end else if (cnt_q != STALL_LIM) begin
          cnt_d = cnt_q + STALL_W'(1);
        end
      end

      ST_FAULT: begin
        // The code is not looked at here; after err_clr IDLE re-evaluates it.
        if (err_clr) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (pos_clr) pos_d = '0;

    err_d     = (state_d == ST_FAULT);
    stalled_d = (state_d == ST_TRACK) && (cnt_d == STALL_LIM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ref_q     <= 2'd0;
      pos_q     <= '0;
      dir_q     <= 1'b1;
      step_q    <= 1'b0;
      err_q     <= 1'b0;
      stalled_q <= 1'b0;
      cnt_q     <= '0;
      php_q     <= 4'b0000;
    end else begin
      state_q   <= state_d;
      ref_q     <= ref_d;
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      err_q     <= err_d;
      stalled_q <= stalled_d;
      cnt_q     <= cnt_d;
      php_q     <= phs;
    end
  end

  assign pos        = pos_q;
  assign dir        = dir_q;
  assign step_pulse = step_q;
  assign err        = err_q;
  assign stalled    = stalled_q;

endmodule
